// File: rtl/regfile_pkg.sv
// regfile_pkg: shared parameter defaults for the scoreboarded register file
package regfile_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_ZERO_REG   = 1;
endpackage

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register busy bits, read-port pending flags and busy count
// Ports: clk, resetN (async active-low); rd_addr1/2 -> pending1/2;
//        wr_addr/wr_eff clear busy; iss_addr/iss_valid set busy; busy_count registered popcount
module register_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = DEF_ZERO_REG
)(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   input  logic [ADDR_WIDTH-1:0] rd_addr2,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  wr_eff,
   input  logic [ADDR_WIDTH-1:0] iss_addr,
   input  logic                  iss_valid,
   output logic                  pending1,
   output logic                  pending2,
   output logic [ADDR_WIDTH:0]   busy_count
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;
   logic [DEPTH-1:0] r_busy;
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] w_set, w_clr;
   logic             w_iss_eff, w_inc, w_dec;
   assign w_iss_eff = iss_valid & ~((ZERO_REG != 0) & (iss_addr == '0));
   assign w_set     = DEPTH'(w_iss_eff) << iss_addr;
   assign w_clr     = DEPTH'(wr_eff) << wr_addr;
   // A write to a register being re-issued this cycle leaves it busy, so no decrement
   assign w_inc     = w_iss_eff & ~r_busy[iss_addr];
   assign w_dec     = wr_eff & r_busy[wr_addr] & ~(w_iss_eff & (iss_addr == wr_addr));
   // The bypassed write satisfies a read in the same cycle
   assign pending1  = r_busy[rd_addr1] & ~(wr_eff & (wr_addr == rd_addr1));
   assign pending2  = r_busy[rd_addr2] & ~(wr_eff & (wr_addr == rd_addr2));
   assign busy_count = r_count;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= (r_busy & ~w_clr) | w_set;
         r_count <= r_count + CW'(w_inc) - CW'(w_dec);
      end
endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: 2R1W register file with zero register, write bypass and RAW scoreboard
// Ports: clk, resetN (async active-low); readRegister1/2 -> readData1/2, pending1/2 (combinational);
//        writeRegister/writeData/regWrite write port; issueRegister/issueValid mark busy;
//        busyCount registered number of busy registers
module scoreboard_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = DEF_ZERO_REG
)(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [ADDR_WIDTH-1:0] readRegister1,
   input  logic [ADDR_WIDTH-1:0] readRegister2,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   output logic                  pending1,
   output logic                  pending2,
   input  logic [ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  regWrite,
   input  logic [ADDR_WIDTH-1:0] issueRegister,
   input  logic                  issueValid,
   output logic [ADDR_WIDTH:0]   busyCount
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic                  w_wr_eff;
   assign w_wr_eff = regWrite & ~((ZERO_REG != 0) & (writeRegister == '0));
   always_ff @(posedge clk or negedge resetN)
      if (!resetN)
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      else if (w_wr_eff)
         r_regs[writeRegister] <= writeData;
   assign readData1 = ((ZERO_REG != 0) && readRegister1 == '0) ? '0 :
                      (w_wr_eff && writeRegister == readRegister1) ? writeData : r_regs[readRegister1];
   assign readData2 = ((ZERO_REG != 0) && readRegister2 == '0) ? '0 :
                      (w_wr_eff && writeRegister == readRegister2) ? writeData : r_regs[readRegister2];
   register_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_sb (
      .clk        (clk),
      .resetN     (resetN),
      .rd_addr1   (readRegister1),
      .rd_addr2   (readRegister2),
      .wr_addr    (writeRegister),
      .wr_eff     (w_wr_eff),
      .iss_addr   (issueRegister),
      .iss_valid  (issueValid),
      .pending1   (pending1),
      .pending2   (pending2),
      .busy_count (busyCount)
   );
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file: scoreboard bench with directed and random stimulus against a reference model
module tb_scoreboard_register_file;
   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [4:0]  readRegister1 = '0, readRegister2 = '0, writeRegister = '0, issueRegister = '0;
   logic [31:0] readData1, readData2, writeData = '0;
   logic        pending1, pending2, regWrite = 1'b0, issueValid = 1'b0;
   logic [5:0]  busyCount;
   scoreboard_register_file dut (
      .clk(clk), .resetN(resetN),
      .readRegister1(readRegister1), .readRegister2(readRegister2),
      .readData1(readData1), .readData2(readData2),
      .pending1(pending1), .pending2(pending2),
      .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
      .issueRegister(issueRegister), .issueValid(issueValid),
      .busyCount(busyCount)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] d1, d2;
      logic        p1, p2;
      logic [5:0]  cnt;
   } exp_t;
   exp_t q[$];
   int n_cmp = 0, n_bad = 0;
   logic [31:0] mem [32];
   bit          busy [32];
   function automatic void model_clear();
      for (int i = 0; i < 32; i++) begin
         mem[i] = '0;
         busy[i] = 1'b0;
      end
   endfunction
   function automatic int popcnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(busy[i]);
      return c;
   endfunction
   function automatic logic [31:0] m_read(input int a, input bit weff, input int wa, input logic [31:0] wd);
      if (a == 0) return '0;
      if (weff && wa == a) return wd;
      return mem[a];
   endfunction
   task automatic cyc(input bit rst, input int r1, input int r2, input bit we, input int wa,
                      input logic [31:0] wd, input bit iv, input int ia, input bit mid);
      exp_t e;
      bit   weff;
      @(posedge clk);
      #1;
      resetN = rst;
      readRegister1 = 5'(r1);
      readRegister2 = 5'(r2);
      regWrite = rst ? we : 1'b0;
      writeRegister = 5'(wa);
      writeData = wd;
      issueValid = rst ? iv : 1'b0;
      issueRegister = 5'(ia);
      if (!rst) model_clear();
      weff = rst && we && wa != 0;
      e.d1 = m_read(r1, weff, wa, wd);
      e.d2 = m_read(r2, weff, wa, wd);
      e.p1 = busy[r1] && !(weff && wa == r1);
      e.p2 = busy[r2] && !(weff && wa == r2);
      e.cnt = 6'(popcnt());
      q.push_back(e);
      if (mid) begin
         #5;
         resetN = 1'b0;
         model_clear();
      end else if (rst) begin
         if (weff) begin
            mem[wa] = wd;
            busy[wa] = 1'b0;
         end
         if (iv && ia != 0) busy[ia] = 1'b1;
      end
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("readData1", readData1, e.d1);
            chk("readData2", readData2, e.d2);
            chk("pending1", 32'(pending1), 32'(e.p1));
            chk("pending2", 32'(pending2), 32'(e.p2));
            chk("busyCount", 32'(busyCount), 32'(e.cnt));
         end
      end
   end
   initial begin : driver
      model_clear();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(1, 2*i, 2*i+1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      cyc(1, 5, 5, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 32'h12345678, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 7, 0, 0, 0, 0, 1, 7, 0);
      for (int i = 0; i < 3; i++) cyc(1, 7, 7, 0, 0, 0, 0, 0, 0);
      cyc(1, 7, 7, 1, 7, 32'h55, 0, 0, 0);
      cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 9, 0, 0, 0, 0, 1, 9, 0);
      cyc(1, 9, 0, 1, 9, 32'h99, 1, 9, 0);
      cyc(1, 9, 3, 1, 9, 32'h9A, 1, 3, 0);
      cyc(1, 3, 9, 0, 0, 0, 0, 0, 0);
      cyc(1, 4, 6, 0, 0, 0, 1, 4, 0);
      cyc(1, 4, 6, 0, 0, 0, 1, 6, 0);
      cyc(1, 4, 6, 1, 4, 32'hAA, 0, 0, 1);
      cyc(0, 4, 6, 0, 0, 0, 0, 0, 0);
      cyc(1, 4, 6, 0, 0, 0, 0, 0, 0);
      cyc(1, 4, 3, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++)
         cyc(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 5, int'($urandom_range(0, 31)), $urandom_range(0, 99) == 0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
